// File: rtl/plic_pkg.sv
// Shared types and constants for the PLIC target: claim FSM states and the reserved "no interrupt" ID.
package plic_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1,
        ST_SETTLE = 2'd2
    } claim_state_t;

    localparam int unsigned PLIC_ID_NONE = 0;
endpackage

// File: rtl/plic_priority_index.sv
// Combinational best-candidate search: highest non-zero priority wins, ties resolve to the lowest ID.
module plic_priority_index
    import plic_pkg::*;
#(
    parameter int SOURCES       = 16,
    parameter int PRIORITY_BITS = 3,
    parameter int ID_BITS       = 5
) (
    input  logic [SOURCES-1:0]                    i_valid,
    input  logic [SOURCES-1:0][PRIORITY_BITS-1:0] i_priority,
    output logic [ID_BITS-1:0]                    o_best_id,
    output logic [PRIORITY_BITS-1:0]              o_best_pri
);
    // Scanning from the top ID down with >= lets a lower ID displace an equal-priority higher one.
    always_comb begin
        o_best_id  = ID_BITS'(PLIC_ID_NONE);
        o_best_pri = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_priority[i] != '0) && (i_priority[i] >= o_best_pri)) begin
                o_best_id  = ID_BITS'(i + 1);
                o_best_pri = i_priority[i];
            end
        end
    end
endmodule

// File: rtl/plic_target.sv
// PLIC target: candidate selection, irq generation, claim/complete handshake and in-service tracking.
// Optional macro PLIC_TARGET_COMPLETE_CHECK_EN: forward completes only for IDs currently in service.
module plic_target
    import plic_pkg::*;
#(
    parameter  int SOURCES       = 16,
    parameter  int PRIORITIES    = 8,
    localparam int ID_BITS       = $clog2(SOURCES + 1),
    localparam int PRIORITY_BITS = $clog2(PRIORITIES)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [SOURCES-1:0]                    i_ip,
    input  logic [SOURCES-1:0]                    i_ie,
    input  logic [SOURCES-1:0][PRIORITY_BITS-1:0] i_priority,
    input  logic [PRIORITY_BITS-1:0]              i_threshold,
    output logic                                  o_irq,
    input  logic                                  i_claim_req,
    output logic                                  o_claim_ack,
    output logic [ID_BITS-1:0]                    o_claim_id,
    input  logic                                  i_complete_req,
    input  logic [ID_BITS-1:0]                    i_complete_id,
    output logic [SOURCES-1:0]                    o_claim,
    output logic [SOURCES-1:0]                    o_complete
);
    claim_state_t             r_state;
    logic                     r_settle_cnt;
    logic                     r_claim_ack;
    logic [ID_BITS-1:0]       r_claim_id;
    logic [SOURCES-1:0]       r_claim;
    logic [SOURCES-1:0]       r_complete;
    logic [SOURCES-1:0]       r_in_service;
    logic [ID_BITS-1:0]       r_best_id;
    logic [PRIORITY_BITS-1:0] r_best_pri;
    logic                     r_irq;
    logic                     r_pend_valid;
    logic [ID_BITS-1:0]       r_pend_id;

    logic [SOURCES-1:0]       w_cand;
    logic [ID_BITS-1:0]       w_best_id;
    logic [PRIORITY_BITS-1:0] w_best_pri;
    logic                     w_claim_fire;
    logic [ID_BITS-1:0]       w_claim_sel_id;
    logic                     w_in_valid;
    logic                     w_sel_valid;
    logic [ID_BITS-1:0]       w_sel_id;
    logic                     w_defer;
    logic                     w_cmp_do;
    logic [SOURCES-1:0]       w_claim_hot;
    logic [SOURCES-1:0]       w_cmp_hot;
    logic [SOURCES-1:0]       w_cmp_fwd;

    assign w_cand = i_ip & i_ie & ~r_in_service;

    plic_priority_index #(
        .SOURCES      (SOURCES),
        .PRIORITY_BITS(PRIORITY_BITS),
        .ID_BITS      (ID_BITS)
    ) u_index (
        .i_valid   (w_cand),
        .i_priority(i_priority),
        .o_best_id (w_best_id),
        .o_best_pri(w_best_pri)
    );

    assign w_claim_fire   = (r_state == ST_IDLE) && i_claim_req;
    assign w_claim_sel_id = (r_best_pri > i_threshold) ? r_best_id : ID_BITS'(PLIC_ID_NONE);

    // A complete that lands on the same edge as the claim of that ID is held one cycle so it
    // acts on the freshly set in-service bit instead of being lost.
    assign w_in_valid  = i_complete_req && (i_complete_id != '0) && (32'(i_complete_id) <= 32'(SOURCES));
    assign w_sel_valid = r_pend_valid || w_in_valid;
    assign w_sel_id    = r_pend_valid ? r_pend_id : i_complete_id;
    assign w_defer     = w_sel_valid && w_claim_fire && (w_sel_id == w_claim_sel_id);
    assign w_cmp_do    = w_sel_valid && !w_defer;

    generate
        for (genvar gi = 0; gi < SOURCES; gi++) begin : g_decode
            assign w_claim_hot[gi] = w_claim_fire && (w_claim_sel_id == ID_BITS'(gi + 1));
            assign w_cmp_hot[gi]   = w_cmp_do && (w_sel_id == ID_BITS'(gi + 1));
        end
    endgenerate

`ifdef PLIC_TARGET_COMPLETE_CHECK_EN
    assign w_cmp_fwd = w_cmp_hot & r_in_service;
`else
    assign w_cmp_fwd = w_cmp_hot;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_id    <= '0;
            r_best_pri   <= '0;
            r_irq        <= 1'b0;
            r_in_service <= '0;
            r_complete   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_id    <= '0;
        end else begin
            r_best_id    <= w_best_id;
            r_best_pri   <= w_best_pri;
            r_irq        <= (r_best_pri > i_threshold);
            r_in_service <= (r_in_service | w_claim_hot) & ~w_cmp_hot;
            r_complete   <= w_cmp_fwd;
            if (w_defer) begin
                r_pend_valid <= 1'b1;
                r_pend_id    <= w_sel_id;
            end else if (r_pend_valid && w_in_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_id    <= i_complete_id;
            end else begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Claim handshake; SETTLE lasts two cycles so the gateway can drop ip before the next claim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 1'b0;
            r_claim_ack  <= 1'b0;
            r_claim_id   <= '0;
            r_claim      <= '0;
        end else begin
            r_claim_ack <= 1'b0;
            r_claim_id  <= '0;
            r_claim     <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (i_claim_req) begin
                        r_state     <= ST_ACK;
                        r_claim_ack <= 1'b1;
                        r_claim_id  <= w_claim_sel_id;
                        r_claim     <= w_claim_hot;
                    end
                end
                ST_ACK: begin
                    r_state      <= ST_SETTLE;
                    r_settle_cnt <= 1'b0;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_settle_cnt <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_irq       = r_irq;
    assign o_claim_ack = r_claim_ack;
    assign o_claim_id  = r_claim_id;
    assign o_claim     = r_claim;
    assign o_complete  = r_complete;
endmodule
